addsub_bist16: RTL and testbench

Hardware stimulus/checker for the 16-bit adder/subtractor (adder_16bit_s). It drives A, B and Add_ctrl into the adder, samples SUM, C_out and O, and compares them against an internal golden model. It counts mismatches per field and reports pass/fail. The block is the on-chip counterpart of the file-driven simulation bench, built for FPGA bring-up and BIST.

---
 rtl/addsub_bist16_if.sv | 13 +
 rtl/addsub_bist16.sv | 171 +++++++++++++++++
 tb/tb_addsub_bist16.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/addsub_bist16_if.sv
// Operand/result bus between the add/sub BIST engine and the 16-bit adder under test.
// The master drives operands and samples results; the slave is the adder.
interface addsub_bist16_if;
  logic [15:0] A;
  logic [15:0] B;
  logic        Add_ctrl;
  logic [15:0] SUM;
  logic        C_out;
  logic        O;

  modport master (output A, B, Add_ctrl, input SUM, C_out, O);
  modport slave  (input A, B, Add_ctrl, output SUM, C_out, O);
endinterface

// File: rtl/addsub_bist16.sv
// BIST stimulus/checker for a 16-bit adder/subtractor: directed corners, then LFSR patterns.
// Optional macro ADDSUB_BIST_STOP_ON_FAIL_EN ends the run at the first mismatching pattern.
module addsub_bist16 #(
  parameter int unsigned NUM_PATTERNS  = 10000,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [31:0] SEED          = 32'hACE1_2468
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  addsub_bist16_if.master adder,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [16:0]     err_count,
  output logic [13:0]     pat_count
);

  localparam logic [31:0]      LFSR_MASK = 32'h8020_0003;
  localparam int unsigned      SET_W     = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
  localparam logic [SET_W-1:0] SET_LAST  = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [13:0]      PAT_LAST  = 14'(NUM_PATTERNS - 1);

`ifdef ADDSUB_BIST_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [15:0]      a_q, b_q;
  logic             ctrl_q;
  logic [31:0]      lfsr_q;
  logic [16:0]      err_q;
  logic [13:0]      pat_q;
  logic [SET_W-1:0] set_cnt_q;

  logic             clear_run, load_ops, do_check, advance;
  logic [15:0]      op_a, op_b;
  logic             op_ctrl;
  logic [31:0]      op_lfsr, lfsr_adv;
  logic [17:0]      gold;
  logic [1:0]       n_mis;

  // Galois form, shifting right; the mask holds taps x^32, x^22, x^2, x^1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

  function automatic logic [16:0] sat_add(input logic [16:0] cnt, input logic [1:0] inc);
    logic [17:0] sum;
    sum = {1'b0, cnt} + {16'd0, inc};
    return sum[17] ? 17'h1FFFF : sum[16:0];
  endfunction

  // Returns {O, C, S}; subtraction is A + ~B + 1, so C=1 means no borrow.
  function automatic logic [17:0] golden(input logic [15:0] a, input logic [15:0] b,
                                         input logic add);
    logic [15:0] bp;
    logic [16:0] r;
    logic        ov;
    bp = add ? b : ~b;
    r  = {1'b0, a} + {1'b0, bp} + {16'd0, ~add};
    ov = (a[15] == bp[15]) && (r[15] != a[15]);
    return {ov, r};
  endfunction

  always_comb begin
    gold  = golden(a_q, b_q, ctrl_q);
    n_mis = {1'b0, (adder.SUM != gold[15:0])} + {1'b0, (adder.C_out != gold[16])}
          + {1'b0, (adder.O != gold[17])};
  end

  always_comb begin
    lfsr_adv = lfsr_step(lfsr_q);
    op_lfsr  = lfsr_q;
    op_a     = 16'h0000;
    op_b     = 16'h0000;
    op_ctrl  = 1'b1;
    case (pat_q)
      14'd0:   begin op_a = 16'h7FFF; op_b = 16'h0001; op_ctrl = 1'b1; end
      14'd1:   begin op_a = 16'h8000; op_b = 16'h0001; op_ctrl = 1'b0; end
      14'd2:   begin op_a = 16'hFFFF; op_b = 16'h0001; op_ctrl = 1'b1; end
      14'd3:   begin op_a = 16'h0000; op_b = 16'h0000; op_ctrl = 1'b0; end
      default: begin
        op_a    = lfsr_adv[31:16];
        op_b    = lfsr_adv[15:0];
        op_ctrl = lfsr_adv[31] ^ lfsr_adv[0];
        op_lfsr = lfsr_adv;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    clear_run = 1'b0;
    load_ops  = 1'b0;
    do_check  = 1'b0;
    advance   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          clear_run = 1'b1;
          state_d   = S_DRIVE;
        end
      end
      S_DRIVE: begin
        load_ops = 1'b1;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (set_cnt_q == SET_LAST) state_d = S_CHECK;
      end
      S_CHECK: begin
        do_check = 1'b1;
        if ((pat_q == PAT_LAST) || (STOP_ON_FAIL && (n_mis != 2'd0))) begin
          state_d = S_DONE;
        end else begin
          advance = 1'b1;
          state_d = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= 16'h0000;
      b_q       <= 16'h0000;
      ctrl_q    <= 1'b1;
      lfsr_q    <= SEED;
      err_q     <= 17'd0;
      pat_q     <= 14'd0;
      set_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (clear_run) begin
        err_q  <= 17'd0;
        pat_q  <= 14'd0;
        lfsr_q <= SEED;
      end
      if (load_ops) begin
        a_q       <= op_a;
        b_q       <= op_b;
        ctrl_q    <= op_ctrl;
        lfsr_q    <= op_lfsr;
        set_cnt_q <= '0;
      end else if (state_q == S_SETTLE) begin
        set_cnt_q <= set_cnt_q + SET_W'(1);
      end
      if (do_check) begin
        err_q <= sat_add(err_q, n_mis);
        if (advance) pat_q <= pat_q + 14'd1;
      end
    end
  end

  assign adder.A        = a_q;
  assign adder.B        = b_q;
  assign adder.Add_ctrl = ctrl_q;
  assign busy           = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign done           = (state_q == S_DONE);
  assign pass           = (state_q == S_DONE) && (err_q == 17'd0);
  assign err_count      = err_q;
  assign pat_count      = pat_q;

endmodule

// File: tb/tb_addsub_bist16.sv
// Bench for addsub_bist16: behavioural adder with injectable faults, directed operand table,
// per-pattern operand/progress checks and end-of-run result checks.
module tb_addsub_bist16;
  localparam int          NP   = 12;
  localparam int          SC   = 2;
  localparam logic [31:0] SEED = 32'hACE1_2468;

`ifdef ADDSUB_BIST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass;
  logic [16:0] err_count;
  logic [13:0] pat_count;
  int          fault = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] exp_a [NP];
  logic [15:0] exp_b [NP];
  logic        exp_c [NP];
  logic [17:0] adder_r;

  addsub_bist16_if bus();

  addsub_bist16 #(.NUM_PATTERNS(NP), .SETTLE_CYCLES(SC), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .adder(bus), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .pat_count(pat_count)
  );

  always #5 clk = ~clk;

  // Reference adder {O, C, S}: carry from unsigned compare, overflow from signed range.
  function automatic logic [17:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                          input logic add);
    logic signed [16:0] sa, sb, sr;
    logic [15:0] s;
    logic        c;
    sa = {a[15], a};
    sb = {b[15], b};
    if (add) begin
      {c, s} = {1'b0, a} + {1'b0, b};
      sr = sa + sb;
    end else begin
      s  = a - b;
      c  = (a >= b);
      sr = sa - sb;
    end
    return {(sr[16] != sr[15]), c, s};
  endfunction

  function automatic logic [17:0] apply_fault(input logic [17:0] r, input int f);
    logic [17:0] o;
    o = r;
    case (f)
      1: o[0]  = 1'b0;
      2: o[17] = ~o[17];
      3: o[16] = ~o[16];
      default: ;
    endcase
    return o;
  endfunction

  always_comb adder_r = apply_fault(ref_add(bus.A, bus.B, bus.Add_ctrl), fault);
  assign bus.SUM   = adder_r[15:0];
  assign bus.C_out = adder_r[16];
  assign bus.O     = adder_r[17];

  function automatic logic [31:0] tb_lfsr(input logic [31:0] s);
    logic        fb;
    logic [31:0] n;
    fb    = s[0];
    n     = {fb, s[31:1]};
    n[21] = s[22] ^ fb;
    n[1]  = s[2] ^ fb;
    n[0]  = s[1] ^ fb;
    return n;
  endfunction

  function automatic int nmis(input int p, input int f);
    logic [17:0] g, x;
    g = ref_add(exp_a[p], exp_b[p], exp_c[p]);
    x = apply_fault(g, f);
    return int'(g[15:0] != x[15:0]) + int'(g[16] != x[16]) + int'(g[17] != x[17]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic build_tbl();
    logic [31:0] s;
    exp_a[0] = 16'h7FFF; exp_b[0] = 16'h0001; exp_c[0] = 1'b1;
    exp_a[1] = 16'h8000; exp_b[1] = 16'h0001; exp_c[1] = 1'b0;
    exp_a[2] = 16'hFFFF; exp_b[2] = 16'h0001; exp_c[2] = 1'b1;
    exp_a[3] = 16'h0000; exp_b[3] = 16'h0000; exp_c[3] = 1'b0;
    exp_a[4] = 16'h5670; exp_b[4] = 16'h9234; exp_c[4] = 1'b0;
    exp_a[5] = 16'h2B38; exp_b[5] = 16'h491A; exp_c[5] = 1'b0;
    exp_a[6] = 16'h159C; exp_b[6] = 16'h248D; exp_c[6] = 1'b1;
    s = 32'h159C_248D;
    for (int p = 7; p < NP; p++) begin
      s = tb_lfsr(s);
      exp_a[p] = s[31:16];
      exp_b[p] = s[15:0];
      exp_c[p] = s[31] ^ s[0];
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".A"}, 32'(bus.A), 32'h0);
    chk({tag, ".B"}, 32'(bus.B), 32'h0);
    chk({tag, ".ctrl"}, 32'(bus.Add_ctrl), 32'h1);
    chk({tag, ".busy"}, 32'(busy), 32'h0);
    chk({tag, ".done"}, 32'(done), 32'h0);
    chk({tag, ".pass"}, 32'(pass), 32'h0);
    chk({tag, ".err"}, 32'(err_count), 32'h0);
    chk({tag, ".pat"}, 32'(pat_count), 32'h0);
  endtask

  // Starts a run and checks every pattern's operands plus the final verdict and timing.
  task automatic do_run(input string tag, input int f, input bit glitch);
    int exp_err, exp_pat, runs, acc, n;
    bit stopped;
    fault   = f;
    exp_err = 0;
    exp_pat = NP - 1;
    stopped = 1'b0;
    for (int p = 0; p < NP; p++) begin
      if (!stopped) begin
        n = nmis(p, f);
        exp_err += n;
        if (STOP && n != 0) begin
          stopped = 1'b1;
          exp_pat = p;
        end
      end
    end
    runs = exp_pat + 1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk({tag, ".busy0"}, 32'(busy), 32'h1);
    chk({tag, ".done0"}, 32'(done), 32'h0);
    repeat (2) @(negedge clk);
    acc = 0;
    for (int p = 0; p < runs; p++) begin
      chk($sformatf("%s.A%0d", tag, p), 32'(bus.A), 32'(exp_a[p]));
      chk($sformatf("%s.B%0d", tag, p), 32'(bus.B), 32'(exp_b[p]));
      chk($sformatf("%s.ctrl%0d", tag, p), 32'(bus.Add_ctrl), 32'(exp_c[p]));
      chk($sformatf("%s.pat%0d", tag, p), 32'(pat_count), 32'(p));
      chk($sformatf("%s.err%0d", tag, p), 32'(err_count), 32'(acc));
      acc += nmis(p, f);
      if (p < runs - 1) begin
        if (glitch && p == 1) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);
      end
    end
    @(negedge clk);
    chk({tag, ".done_early"}, 32'(done), 32'h0);
    @(negedge clk);
    chk({tag, ".done"}, 32'(done), 32'h1);
    chk({tag, ".busy"}, 32'(busy), 32'h0);
    chk({tag, ".err"}, 32'(err_count), 32'(exp_err));
    chk({tag, ".pat"}, 32'(pat_count), 32'(exp_pat));
    chk({tag, ".pass"}, 32'(pass), 32'(exp_err == 0));
    repeat (3) @(negedge clk);
    chk({tag, ".hold"}, 32'(done), 32'h1);
  endtask

  task automatic abort_run(input int after);
    fault = 2;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (after) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset("abort");
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    build_tbl();
    #1 rst = 1'b1;
    #1 chk_reset("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle.done", 32'(done), 32'h0);
    do_run("good", 0, 1'b0);
    do_run("sum0", 1, 1'b0);
    do_run("oinv", 2, 1'b0);
    abort_run(30);
    do_run("rerun", 0, 1'b0);
    do_run("glitch", 0, 1'b1);
    do_run("cinv", 3, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
